echo_requester: RTL and testbench

ECHO_REQUESTER -- requirements
Module: echo_requester

---
 rtl/echo_requester.sv | 135 +++++++++++++
 tb/tb_echo_requester.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_requester.sv
// Echo requester: issues a run of incrementing request values toward an echo
// responder, checks in-order responses and reports counts, errors and timeouts.
module echo_requester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start__ENA,
  output logic        start__RDY,
  input  logic [15:0] start_count,
  input  logic [31:0] start_seed,
  output logic        echoReq__ENA,
  output logic [31:0] echoReq_v,
  input  logic        echoReq__RDY,
  input  logic        ind_echo__ENA,
  input  logic [31:0] ind_echo_v,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] rx_count,
  output logic [15:0] err_count,
  output logic [31:0] first_err_v,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT);

  logic [1:0]  state;
  logic [15:0] count;
  logic [31:0] seed;
  logic [15:0] sent;
  logic [3:0]  outstanding;
  logic [15:0] timer;
  logic        err_seen;

  logic active;
  logic issue;
  logic rsp_ok;
  logic rsp_bad;
  logic mismatch;
  logic err_inc;
  logic tmr_hit;

  // Handshake: a request transfers on every cycle echoReq__ENA is high, which
  // is only ever asserted while echoReq__RDY is high; responses are single-cycle
  // strobes that are always accepted.
  always_comb begin
    active   = (state == SEND) || (state == DRAIN);
    issue    = (state == SEND) && echoReq__RDY && (outstanding < MAX_OUT) && (sent < count);
    rsp_ok   = active && ind_echo__ENA && (outstanding != 4'd0);
    rsp_bad  = ind_echo__ENA && !rsp_ok;
    mismatch = rsp_ok && (ind_echo_v != (seed + {16'd0, rx_count}));
    err_inc  = rsp_bad || mismatch;
    tmr_hit  = active && (outstanding != 4'd0) && !ind_echo__ENA &&
               (({1'b0, timer} + 17'd1) == TMO_LIMIT);
  end

  assign start__RDY   = (state == IDLE);
  assign busy         = active;
  assign done         = (state == DONE);
  assign echoReq__ENA = issue;
  assign echoReq_v    = seed + {16'd0, sent};
  assign dbg_state    = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      count       <= 16'd0;
      seed        <= 32'd0;
      sent        <= 16'd0;
      outstanding <= 4'd0;
      timer       <= 16'd0;
      rx_count    <= 16'd0;
      err_count   <= 16'd0;
      first_err_v <= 32'd0;
      err_seen    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (err_inc) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!err_seen) begin
          first_err_v <= ind_echo_v;
          err_seen    <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          // A start overrides any stray response seen in the same cycle.
          if (start__ENA) begin
            count       <= start_count;
            seed        <= start_seed;
            sent        <= 16'd0;
            outstanding <= 4'd0;
            timer       <= 16'd0;
            rx_count    <= 16'd0;
            err_count   <= 16'd0;
            first_err_v <= 32'd0;
            err_seen    <= 1'b0;
            timeout     <= 1'b0;
            state       <= (start_count == 16'd0) ? DONE : SEND;
          end
        end
        SEND, DRAIN: begin
          if (issue)  sent     <= sent + 16'd1;
          if (rsp_ok) rx_count <= rx_count + 16'd1;
          case ({issue, rsp_ok})
            2'b10:   outstanding <= outstanding + 4'd1;
            2'b01:   outstanding <= outstanding - 4'd1;
            default: outstanding <= outstanding;
          endcase
          if (ind_echo__ENA)            timer <= 16'd0;
          else if (outstanding != 4'd0) timer <= timer + 16'd1;
          if (tmr_hit) begin
            timeout     <= 1'b1;
            outstanding <= 4'd0;
            state       <= DONE;
          end else if ((state == SEND) && issue && ((sent + 16'd1) == count)) begin
            state <= DRAIN;
          end else if ((state == DRAIN) && rsp_ok && ((rx_count + 16'd1) == count)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_requester.sv
// Bench for echo_requester: directed runs against a behavioural run model, an
// expected-request queue and an echo responder with hold/drop/corrupt modes.
module tb_echo_requester;

  localparam int MAXO = 4;
  localparam int TMO  = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start__ENA = 1'b0;
  logic [15:0] start_count = 16'd0;
  logic [31:0] start_seed = 32'd0;
  logic        echoReq__RDY = 1'b1;
  logic        ind_echo__ENA = 1'b0;
  logic [31:0] ind_echo_v = 32'd0;
  logic        start__RDY, echoReq__ENA, busy, done, timeout;
  logic [31:0] echoReq_v, first_err_v;
  logic [15:0] rx_count, err_count;
  logic [1:0]  dbg_state;

  echo_requester #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .start__ENA(start__ENA), .start__RDY(start__RDY),
    .start_count(start_count), .start_seed(start_seed),
    .echoReq__ENA(echoReq__ENA), .echoReq_v(echoReq_v), .echoReq__RDY(echoReq__RDY),
    .ind_echo__ENA(ind_echo__ENA), .ind_echo_v(ind_echo_v),
    .busy(busy), .done(done), .timeout(timeout),
    .rx_count(rx_count), .err_count(err_count), .first_err_v(first_err_v),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Run model: phase 0 idle, 1 sending, 2 draining, 3 finished.
  int          m_phase = 0;
  int unsigned m_count, m_sent, m_rx, m_out, m_err, m_tmr;
  logic [31:0] m_seed, m_ferr;
  bit          m_to, m_eseen, m_valid = 0;
  bit          m_iss, m_ok, m_bad, m_mis;
  int unsigned m_out_old;
  int          cyc = 0;
  logic [31:0] exp_q[$];

  function automatic bit model_issue();
    return (m_phase == 1) && echoReq__RDY && (m_out < MAXO) && (m_sent < m_count);
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (RST) begin
      m_phase = 0; m_count = 0; m_sent = 0; m_rx = 0; m_out = 0; m_err = 0; m_tmr = 0;
      m_seed = 0; m_ferr = 0; m_to = 0; m_eseen = 0; m_valid = 1;
      exp_q.delete();
    end else begin
      m_iss = model_issue();
      m_ok  = (m_phase == 1 || m_phase == 2) && ind_echo__ENA && (m_out > 0);
      m_bad = ind_echo__ENA && !m_ok;
      m_mis = m_ok && (ind_echo_v != m_seed + 32'(m_rx));
      if (m_bad || m_mis) begin
        if (m_err < 65535) m_err++;
        if (!m_eseen) begin m_ferr = ind_echo_v; m_eseen = 1; end
      end
      if (m_phase == 0) begin
        if (start__ENA) begin
          m_count = start_count; m_seed = start_seed;
          m_sent = 0; m_rx = 0; m_out = 0; m_err = 0; m_tmr = 0;
          m_ferr = 0; m_to = 0; m_eseen = 0;
          exp_q.delete();
          for (int k = 0; k < int'(start_count); k++) exp_q.push_back(start_seed + 32'(k));
          m_phase = (start_count == 0) ? 3 : 1;
        end
      end else if (m_phase == 3) begin
        m_phase = 0;
      end else begin
        m_out_old = m_out;
        if (m_ok)  m_rx++;
        if (m_iss) m_sent++;
        m_out = m_out + (m_iss ? 1 : 0) - (m_ok ? 1 : 0);
        if (ind_echo__ENA) m_tmr = 0;
        else if (m_out_old > 0) m_tmr++;
        if (!ind_echo__ENA && m_out_old > 0 && m_tmr == TMO) begin
          m_to = 1; m_out = 0; m_phase = 3;
        end else if (m_phase == 1 && m_iss && m_sent == m_count) begin
          m_phase = 2;
        end else if (m_phase == 2 && m_rx == m_count) begin
          m_phase = 3;
        end
      end
    end
  end

  // Per-cycle comparison plus run statistics gathered away from the edge.
  int          n_issued = 0, n_done = 0, last_iss_cyc = 0, done_cyc = 0;
  logic [31:0] iss_log[$];

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("start_rdy", 32'(start__RDY), 32'(m_phase == 0));
      chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("rx_count", 32'(rx_count), m_rx);
      chk("err_count", 32'(err_count), m_err);
      chk("first_err_v", first_err_v, m_ferr);
      chk("req_ena", 32'(echoReq__ENA), 32'(model_issue()));
      if (echoReq__ENA) begin
        if (exp_q.size() == 0) chk("req_unexpected", 32'(1), 32'(0));
        else chk("req_v", echoReq_v, exp_q.pop_front());
        iss_log.push_back(echoReq_v);
        n_issued++;
        last_iss_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Echo responder: one-cycle latency, optional hold / drop / corrupt.
  logic [31:0] rq[$];
  logic [31:0] rv;
  bit          hold = 0, drop = 0;
  int          corrupt_idx = -1, resp_idx = 0;

  always @(negedge CLK) if (echoReq__ENA && !drop) rq.push_back(echoReq_v);

  always @(posedge CLK) begin
    #2;
    if (!hold && rq.size() > 0) begin
      rv = rq.pop_front();
      if (resp_idx == corrupt_idx) rv = rv ^ 32'h1;
      resp_idx++;
      ind_echo__ENA = 1'b1;
      ind_echo_v    = rv;
    end else begin
      ind_echo__ENA = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  int st_cyc = 0;

  task automatic new_run(input logic [15:0] cnt, input logic [31:0] sd);
    n_issued = 0; n_done = 0; resp_idx = 0;
    iss_log.delete();
    start_count = cnt; start_seed = sd; start__ENA = 1'b1;
    st_cyc = cyc;
    tick(1);
    start__ENA = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b;
    b = 0;
    while (n_done == 0 && b < budget) begin tick(1); b++; end
    checks++;
    if (n_done == 0) begin
      failures++;
      $display("FAIL done_wait actual=no_done required=done_within_%0d", budget);
    end
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_start_rdy", 32'(start__RDY), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ena", 32'(echoReq__ENA), 32'd0);
    chk("rst_rx", 32'(rx_count), 32'd0);
    RST = 1'b0;
    tick(1);

    // Loopback
    new_run(16'd8, 32'h10);
    wait_done(100);
    chk("lb_rx", 32'(rx_count), 32'd8);
    chk("lb_err", 32'(err_count), 32'd0);
    chk("lb_issued", 32'(n_issued), 32'd8);
    chk("lb_first", iss_log[0], 32'h10);
    chk("lb_last", iss_log[7], 32'h17);

    // Wrap-around of request values
    new_run(16'd4, 32'hFFFF_FFFE);
    wait_done(100);
    chk("wr_v0", iss_log[0], 32'hFFFF_FFFE);
    chk("wr_v1", iss_log[1], 32'hFFFF_FFFF);
    chk("wr_v2", iss_log[2], 32'h0);
    chk("wr_v3", iss_log[3], 32'h1);
    chk("wr_err", 32'(err_count), 32'd0);

    // Back-pressure with held replies
    echoReq__RDY = 1'b0; hold = 1;
    new_run(16'd8, 32'h100);
    tick(20);
    chk("bp_no_issue", 32'(n_issued), 32'd0);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_no_timeout", 32'(timeout), 32'd0);
    echoReq__RDY = 1'b1;
    tick(8);
    chk("bp_max_out", 32'(n_issued), 32'd4);
    hold = 0;
    wait_done(100);
    chk("bp_rx", 32'(rx_count), 32'd8);
    chk("bp_err", 32'(err_count), 32'd0);

    // Corrupted third response
    corrupt_idx = 2;
    new_run(16'd5, 32'h0);
    wait_done(100);
    corrupt_idx = -1;
    chk("cor_err", 32'(err_count), 32'd1);
    chk("cor_first", first_err_v, 32'h3);
    chk("cor_rx", 32'(rx_count), 32'd5);

    // Timeout with all replies dropped
    drop = 1;
    new_run(16'd2, 32'h55);
    wait_done(100);
    drop = 0;
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_rx", 32'(rx_count), 32'd0);
    chk("to_issued", 32'(n_issued), 32'd2);
    chk("to_delay", 32'(done_cyc - last_iss_cyc), 32'd16);

    // Zero-length run
    new_run(16'd0, 32'h1);
    tick(2);
    chk("z_done", 32'(n_done), 32'd1);
    chk("z_done_cyc", 32'(done_cyc - st_cyc), 32'd1);
    chk("z_issued", 32'(n_issued), 32'd0);
    chk("z_timeout_clr", 32'(timeout), 32'd0);

    // Reset while draining, then a stray response
    hold = 1;
    new_run(16'd4, 32'h200);
    tick(7);
    chk("rd_issued", 32'(n_issued), 32'd4);
    chk("rd_state", 32'(dbg_state), 32'd2);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk("rd_idle", 32'(start__RDY), 32'd1);
    chk("rd_rx", 32'(rx_count), 32'd0);
    chk("rd_err", 32'(err_count), 32'd0);
    hold = 0;
    tick(1);
    hold = 1;
    rq.delete();
    tick(1);
    chk("rd_stray_err", 32'(err_count), 32'd1);
    chk("rd_stray_rx", 32'(rx_count), 32'd0);
    chk("rd_no_done", 32'(n_done), 32'd0);
    hold = 0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
